// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types, including the instruction-cache state, frame layout and
// address-split widths.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Default geometry. Modules with a different SETS derive their own widths with icache_idx_w().
    localparam int ICACHE_SETS      = 16;
    localparam int ICACHE_IDX_W     = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W     = 30 - ICACHE_IDX_W;
    localparam int ICACHE_TAG_MAX_W = 29;

    // Tags are stored at the width needed by the smallest legal cache (2 sets).
    // Narrower tags are zero-extended, so their upper storage bits stay constant.
    typedef logic [ICACHE_TAG_MAX_W-1:0] icache_tag_t;

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } icache_state_t;

    typedef struct packed {
        logic        valid;
        icache_tag_t tag;
        word_t       data;
    } icache_frame_t;

    function automatic int icache_idx_w(input int sets);
        return $clog2(sets);
    endfunction

endpackage

// File: rtl/icache_frame_array.sv
// Frame storage for the icache. It provides one combinational read port, one
// synchronous write port, and a bulk valid-clear.
module icache_frame_array
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int IDX_W = icache_idx_w(SETS)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output icache_frame_t     rd_frame_o,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  icache_frame_t     wr_frame_i,
    input  logic              clr_all_i
);

    logic [SETS-1:0] valid_q;
    logic [SETS-1:0] valid_d;
    icache_tag_t     tag_q  [SETS];
    word_t           data_q [SETS];

    // The bulk clear is applied after the write, so a fill on the same edge ends up invalid.
    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) begin
            valid_d[wr_idx_i] = wr_frame_i.valid;
        end
        if (clr_all_i) begin
            valid_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_frame_i.tag;
            data_q[wr_idx_i] <= wr_frame_i.data;
        end
    end

    assign rd_frame_o = '{valid: valid_q[rd_idx_i],
                          tag:   tag_q[rd_idx_i],
                          data:  data_q[rd_idx_i]};

endmodule

// File: rtl/icache.sv
// Direct-mapped, single-word-block, read-only instruction cache.
// Optional hit/miss counters are built in when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS  = 16,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  word_t            imemaddr,
    output logic             ihit,
    output word_t            imemload,
    input  logic             inv_all,
    output logic             iREN,
    output word_t            iaddr,
    input  logic             iwait,
    input  word_t            iload
`ifdef ICACHE_STATS_EN
    ,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
`endif
);

    localparam int IDX_W = icache_idx_w(SETS);
    localparam int TAG_W = 30 - IDX_W;

    icache_state_t      state_q;
    word_t              miss_addr_q;
    logic [IDX_W-1:0]   req_idx;
    logic [IDX_W-1:0]   fill_idx;
    logic [TAG_W-1:0]   req_tag;
    logic [TAG_W-1:0]   fill_tag;
    icache_frame_t      rd_frame;
    icache_frame_t      wr_frame;
    logic               miss;
    logic               fill;
    logic [1:0]         unused_addr_bits;

    assign unused_addr_bits = imemaddr[1:0];
    assign req_idx          = imemaddr[IDX_W+1:2];
    assign req_tag          = imemaddr[31:IDX_W+2];
    assign fill_idx         = miss_addr_q[IDX_W+1:2];
    assign fill_tag         = miss_addr_q[31:IDX_W+2];

    // Hits are answered only from IDLE. Responses never depend on iwait or iload.
    assign ihit     = (state_q == IDLE) && imemREN && rd_frame.valid
                      && (rd_frame.tag == icache_tag_t'(req_tag));
    assign imemload = rd_frame.data;
    assign miss     = (state_q == IDLE) && imemREN && !ihit;
    assign fill     = (state_q == FETCH) && !iwait;
    assign wr_frame = '{valid: 1'b1, tag: icache_tag_t'(fill_tag), data: iload};

    assign iREN  = (state_q == FETCH);
    assign iaddr = iREN ? miss_addr_q : '0;

    icache_frame_array #(
        .SETS  (SETS),
        .IDX_W (IDX_W)
    ) u_frames (
        .clk_i      (CLK),
        .rst_ni     (nRST),
        .rd_idx_i   (req_idx),
        .rd_frame_o (rd_frame),
        .wr_en_i    (fill),
        .wr_idx_i   (fill_idx),
        .wr_frame_i (wr_frame),
        .clr_all_i  (inv_all)
    );

    // Once a miss is latched, the read always runs to completion, whatever the pipeline does meanwhile.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (miss) begin
                        miss_addr_q <= {imemaddr[31:2], 2'b00};
                        state_q     <= FETCH;
                    end
                end
                FETCH: begin
                    if (!iwait) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [CNT_W-1:0] hit_count_q;
    logic [CNT_W-1:0] miss_count_q;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if (ihit) begin
                hit_count_q <= hit_count_q + CNT_W'(1);
            end
            if (miss) begin
                miss_count_q <= miss_count_q + CNT_W'(1);
            end
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
`else
    localparam int unused_cnt_w = CNT_W;
`endif

    a_no_hit_in_fetch: assert property (@(posedge CLK) disable iff (!nRST)
        (state_q == FETCH) |-> !ihit);

    a_fetch_addr_stable: assert property (@(posedge CLK) disable iff (!nRST)
        (state_q == FETCH && iwait) |=> (iREN && iaddr == $past(iaddr)));

endmodule

// File: doc/icache.md
# icache

Direct-mapped, single-word-block instruction cache between the pipeline fetch stage and the memory controller. It answers fetch requests with `ihit`/`imemload`, which drive the pipeline-register enables and the PC write enable. On a miss it becomes the initiator toward the memory controller: it holds `iREN` until `iwait` drops, then refills the frame. The cache is read-only; no write-back path exists.

## Interface
Parameters:
- `SETS`, 16 — number of frames; a power of two, 2..1024; `IDX_W = $clog2(SETS)`
- `CNT_W`, 32 — statistics counter width (used only with `ICACHE_STATS_EN`)

Ports:
- `CLK`  in  1  — clock; all state updates on the rising edge
- `nRST`  in  1  — reset; asynchronous, active-low
- `imemREN`  in  1  — pipeline fetch request
- `imemaddr`  in  32  — fetch byte address; bits [1:0] are ignored
- `ihit`  out  1  — fetch satisfied this cycle
- `imemload`  out  32  — instruction word; valid only when `ihit`=1
- `inv_all`  in  1  — synchronous invalidate of every frame
- `iREN`  out  1  — memory read request
- `iaddr`  out  32  — memory read address, word-aligned
- `iwait`  in  1  — memory busy; a low level while `iREN`=1 completes the read
- `iload`  in  32  — memory read data, valid when `iREN`=1 and `iwait`=0
- `hit_count`  out  CNT_W  — present only with `ICACHE_STATS_EN`
- `miss_count`  out  CNT_W  — present only with `ICACHE_STATS_EN`

## Operation
- Address split: index = `imemaddr[IDX_W+1:2]`, tag = `imemaddr[31:IDX_W+2]`. Each frame holds `valid`, `tag`, `data[31:0]`.
- FSM states are IDLE and FETCH. The FSM resets to IDLE.
- IDLE:
  - `ihit` = `imemREN` & `valid[idx]` & (`tag[idx]`==req tag). `imemload` = `data[idx]`, driven combinationally.
  - On `imemREN` & !hit: latch `{imemaddr[31:2],2'b00}` into `miss_addr` and go to FETCH.
- FETCH:
  - `ihit`=0. `iREN`=1. `iaddr`=`miss_addr`.
  - Stay in FETCH while `iwait`=1.
  - When `iwait`=0: write frame[`miss_addr` index] with `valid`=1, tag, and `data`=`iload`. Go to IDLE.
- The outstanding read always completes, even if `imemREN` falls or `imemaddr` changes during FETCH. After the fill, IDLE re-evaluates the current address.
- `inv_all`:
  - Clears all `valid` bits at the next edge.
  - If it coincides with the fill edge, the invalidate wins and the filled frame ends invalid.
  - It does not abort FETCH.
- Outside FETCH, `iREN`=0 and `iaddr`=0.
- Reset (asserted at any time, including mid-FETCH):
  - All `valid`=0, state=IDLE, `miss_addr`=0, counters=0.
  - `iREN`=0, `iaddr`=0, `ihit`=0 immediately.
  - Tag and data arrays need no reset.
- Reset output values: `ihit`=0, `imemload`=don't-care (drive 0 is acceptable), `iREN`=0, `iaddr`=0, `hit_count`=0, `miss_count`=0.

## Timing
- Hit latency is zero cycles: `ihit` and `imemload` respond combinationally in the request cycle.
- Miss sequence:
  - Cycle 0: miss detected in IDLE.
  - Cycle 1: first FETCH cycle with `iREN`=1.
  - Cycle k: `iwait` is low and the frame is written at the end of the cycle.
  - Cycle k+1: IDLE with `ihit`=1.
  - Minimum miss-to-hit latency is 2 cycles (`iwait` low in cycle 1).
- `iREN` and `iaddr` are stable for the whole FETCH interval.
- No combinational path from `iwait`/`iload` to `ihit`/`imemload`.

## Configuration
- `ICACHE_STATS_EN` defined:
  - `hit_count` increments on every cycle with `ihit`=1, including repeated cycles while the pipeline stalls on the same address.
  - `miss_count` increments on every IDLE→FETCH transition.
  - Both counters wrap modulo 2^CNT_W.
- `ICACHE_STATS_EN` undefined: the counters, their ports, and their logic are absent. Hit/miss behaviour is identical in both builds.

## Structure
- `cpu_types_pkg` gains:
  - `icache_state_t` (IDLE, FETCH)
  - `icache_frame_t` (`valid`, `tag`, `data`)
  - the address-split field widths as localparams derived from `SETS`
- `word_t` from `cpu_types_pkg` is used for all 32-bit data.
- Natural sub-module: `icache_frame_array`, holding the frame storage with one combinational read port, one synchronous write port, and a bulk valid-clear.

## Test plan
- Reset, then `imemREN`=1, `imemaddr`=0x0000_0000, with `iwait` high for 2 cycles then low and `iload`=0xDEADBEEF:
  - `iREN`=1 and `iaddr`=0x0 for cycles 1–3.
  - `ihit`=1 and `imemload`=0xDEADBEEF in cycle 4.
  - `miss_count`=1.
- Re-request 0x0000_0002 → `ihit`=1 in the same cycle, `imemload`=0xDEADBEEF, `iREN` never rises.
- Conflict with `SETS`=16: fetch 0x40 (index 0, new tag) → miss with `iaddr`=0x40. Then 0x0 misses again.
- `imemaddr` switches from 0x8 to 0xC mid-FETCH:
  - Fill of 0x8 completes.
  - The next cycle misses on 0xC.
  - A later access to 0x8 hits.
- `inv_all` pulse, then fetch a previously cached address → miss. Also assert `inv_all` on the fill edge → the following cycle still misses.
- Assert `nRST` low during FETCH → `iREN`=0 with no clock edge. After release, a previously cached address misses and the counters read 0.
